uart_tx: RTL and testbench

//  8N1 UART transmitter. The peer of uart_rx on the serial link: serialises bytes from an
//  on-chip producer (valid/ready) onto txd, LSB first. Bit timing uses the same formula as

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx.sv | 98 +++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART blocks: state encodings,
// default line parameters and the bit-period helper.
package uart_tx_pkg;

    localparam int DEF_CLOCK_SPEED = 100_000_000;
    localparam int DEF_BAUD_RATE   = 9600;

    // Encodings are shared with uart_rx; keep them stable.
    typedef enum logic [3:0] {
        ST_START = 4'h0,
        ST_D0    = 4'h1,
        ST_D1    = 4'h2,
        ST_D2    = 4'h3,
        ST_D3    = 4'h4,
        ST_D4    = 4'h5,
        ST_D5    = 4'h6,
        ST_D6    = 4'h7,
        ST_D7    = 4'h8,
        ST_STOP  = 4'hA,
        ST_IDLE  = 4'hF
    } state_t;

    function automatic int clocks_per_bit(
        input int clk_hz,
        input int baud
    );
        return (clk_hz / baud) + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs while enabled, pulses bit_tick on the
// terminal count and wraps to zero. Held at zero while disabled.
module uart_baud_gen #(
    parameter int CLOCKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W =
        (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = en && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte input, LSB-first serial
// output on a registered txd, configurable 1 or 2 stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_SPEED = DEF_CLOCK_SPEED,
    parameter int BAUD_RATE   = DEF_BAUD_RATE,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);

    localparam int CLOCKS_PER_BIT =
        clocks_per_bit(CLOCK_SPEED, BAUD_RATE);

    state_t     state;
    logic [7:0] shreg;
    logic       stop_cnt;
    logic       bit_tick;
    logic       baud_en;
    logic       last_stop;

    assign tx_ready  = (state == ST_IDLE);
    assign baud_en   = (state != ST_IDLE);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (baud_en),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        state   <= ST_START;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                ST_START, ST_D0, ST_D1, ST_D2,
                ST_D3, ST_D4, ST_D5, ST_D6: begin
                    // txd carries the bit leaving the shifter
                    if (bit_tick) begin
                        state <= state_t'(state + 4'd1);
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                ST_D7: begin
                    if (bit_tick) begin
                        state    <= ST_STOP;
                        txd      <= 1'b1;
                        shreg    <= shreg >> 1;
                        stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            state    <= ST_IDLE;
                            tx_busy  <= 1'b0;
                            stop_cnt <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    shreg    <= '0;
                    txd      <= 1'b1;
                    tx_busy  <= 1'b0;
                    stop_cnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, random bytes
// against a line model, back-to-back spacing and async reset cases.
module tb_uart_tx;

    localparam int CPB = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;
    logic       ready0, txd0, busy0;
    logic       ready1, txd1, busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(
        .CLOCK_SPEED(160), .BAUD_RATE(10), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(valid0), .tx_ready(ready0),
        .txd(txd0), .tx_busy(busy0)
    );

    uart_tx #(
        .CLOCK_SPEED(160), .BAUD_RATE(10), .STOP_BITS(2)
    ) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(valid1), .tx_ready(ready1),
        .txd(txd1), .tx_busy(busy1)
    );

    typedef struct {
        logic [7:0] data;
        int         chg_cell;
        logic [7:0] chg_data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected line level per bit cell: start, 8 data LSB first, stops.
    function automatic logic [10:0] model_line(input logic [7:0] d);
        logic [10:0] l;
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      l[c] = 1'b0;
            else if (c <= 8) l[c] = 1'((d / (1 << (c - 1))) % 2);
            else             l[c] = 1'b1;
        end
        return l;
    endfunction

    task automatic launch(input int sb, input logic [7:0] d);
        @(posedge clk);
        #1;
        tx_data = d;
        if (sb == 2) valid1 = 1'b1;
        else         valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Checks every cycle of a frame starting at the next negedge,
    // one comparison per bit cell, then the following idle cycle.
    task automatic check_cells(input int sb, input logic [10:0] line,
                               input int chg_cell,
                               input logic [7:0] chg_data,
                               input string name,
                               output int start,
                               output logic [7:0] rxb);
        logic t, b, r, ok;
        start = -1;
        rxb   = 8'h00;
        t = 1'b0; b = 1'b0; r = 1'b0;
        for (int c = 0; c < 9 + sb; c++) begin
            ok = 1'b1;
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                t = (sb == 2) ? txd1 : txd0;
                b = (sb == 2) ? busy1 : busy0;
                r = (sb == 2) ? ready1 : ready0;
                if (c == 0 && j == 0) start = cyc;
                if (c >= 1 && c <= 8 && j == CPB / 2) rxb[c-1] = t;
                if (t !== line[c] || b !== 1'b1 || r !== 1'b0) ok = 1'b0;
                if (c == chg_cell && j == 0) tx_data = chg_data;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s cell %0d txd/busy/ready actual=%b%b%b required=%b10",
                         name, c, t, b, r, line[c]);
            end
        end
        @(negedge clk);
        t = (sb == 2) ? txd1 : txd0;
        b = (sb == 2) ? busy1 : busy0;
        r = (sb == 2) ? ready1 : ready0;
        chk({name, " idle after frame"}, {29'd0, t, b, r}, 32'b101);
    endtask

    initial begin
        int          s1, s2;
        logic [7:0]  rxb, d;
        logic        ok_t, ok_b, ok_r;

        vecs[0] = '{8'hA5, -1, 8'h00, 10'b1101001010};
        vecs[1] = '{8'h3C,  3, 8'hC3, 10'b1001111000};
        vecs[2] = '{8'h01, -1, 8'h00, 10'b1000000010};
        vecs[3] = '{8'h80, -1, 8'h00, 10'b1100000000};

        // Reset and long idle
        repeat (3) @(negedge clk);
        chk("reset txd", {31'd0, txd0}, 32'd1);
        chk("reset busy", {31'd0, busy0}, 32'd0);
        chk("reset ready", {31'd0, ready0}, 32'd1);
        rst = 1'b0;
        ok_t = 1'b1; ok_b = 1'b1; ok_r = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || txd1 !== 1'b1) ok_t = 1'b0;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) ok_b = 1'b0;
            if (ready0 !== 1'b1 || ready1 !== 1'b1) ok_r = 1'b0;
        end
        chk("idle txd", {31'd0, ok_t}, 32'd1);
        chk("idle busy", {31'd0, ok_b}, 32'd1);
        chk("idle ready", {31'd0, ok_r}, 32'd1);

        // Table-driven frames, with a mid-frame data change and rx decode
        for (int i = 0; i < 4; i++) begin
            launch(1, vecs[i].data);
            check_cells(1, {1'b1, vecs[i].line}, vecs[i].chg_cell,
                        vecs[i].chg_data, $sformatf("vec%0d", i), s1, rxb);
            chk($sformatf("vec%0d rx byte", i), {24'd0, rxb},
                {24'd0, vecs[i].data});
        end

        // Back-to-back, one stop bit
        @(posedge clk);
        #1;
        tx_data = 8'h00;
        valid0  = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        check_cells(1, model_line(8'h00), -1, 8'h00, "b2b0 first", s1, rxb);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        check_cells(1, model_line(8'hFF), -1, 8'h00, "b2b0 second", s2, rxb);
        chk("b2b spacing sb1", s2 - s1, 32'd171);

        // Reset mid-frame during D4
        launch(1, 8'hC7);
        repeat (5 * CPB + 8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst txd", {31'd0, txd0}, 32'd1);
        chk("async rst busy", {31'd0, busy0}, 32'd0);
        chk("async rst ready", {31'd0, ready0}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        launch(1, 8'h5A);
        check_cells(1, {1'b1, 10'b1010110100}, -1, 8'h00, "after rst",
                    s1, rxb);
        chk("after rst rx byte", {24'd0, rxb}, 32'h5A);

        // Random bytes with random mid-frame data changes
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            launch(1, d);
            check_cells(1, model_line(d), int'($urandom_range(1, 9)),
                        8'($urandom), $sformatf("rand%0d", i), s1, rxb);
            chk($sformatf("rand%0d rx byte", i), {24'd0, rxb}, {24'd0, d});
        end

        // Back-to-back, two stop bits
        @(posedge clk);
        #1;
        tx_data = 8'h00;
        valid1  = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        check_cells(2, model_line(8'h00), -1, 8'h00, "b2b1 first", s1, rxb);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        check_cells(2, model_line(8'hFF), -1, 8'h00, "b2b1 second", s2, rxb);
        chk("b2b spacing sb2", s2 - s1, 32'd188);

        d = 8'($urandom);
        launch(2, d);
        check_cells(2, model_line(d), -1, 8'h00, "sb2 rand", s1, rxb);
        chk("sb2 rand rx byte", {24'd0, rxb}, {24'd0, d});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
